mul_round_pack: RTL and testbench
=================================

// Module: mul_round_pack
// PURPOSE
//  Final stage of the FP multiplier, directly downstream of the exponent-sum stage.
//  Accepts the raw significand product, the biased exponent sum and the tiny flag.
//  Denormalises tiny results with an iterative right shift of 1 bit/cycle.
//  Rounds to nearest-even and packs a single IEEE word plus overflow/underflow/inexact flags.
//  Valid/ready handshake on both sides; one operation in flight at a time.
// PARAMETERS
//  WEXP    8    exponent field width
//  WFRAC   23   stored fraction width
//  WEXPSUM 10   exponent-sum width, 2's complement (WEXP+2)
//  WPROD   48   significand product width (2*(WFRAC+1))
// PORTS
//  clk        in   1              rising-edge clock, the single clock of the block
//  rst_n      in   1              asynchronous active-low reset
//  in_valid   in   1              upstream operand valid
//  in_ready   out  1              block can accept an operand (high only in IDLE)
//  sign       in   1              product sign
//  expsum     in   WEXPSUM        biased exponent sum; already includes the twoormore increment
//  tiny       in   1              expsum <= 0 (result is subnormal or zero)
//  twoormore  in   1              product is in [2,4): leading one at bit WPROD-1, else at bit WPROD-2
//  prod       in   WPROD          raw significand product
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts result
//  result     out  1+WEXP+WFRAC   {sign, exp, frac}
//  overflow   out  1              result overflowed to infinity
//  underflow  out  1              result is tiny AND inexact
//  inexact    out  1              rounding discarded nonzero bits
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0.
//  FSM states are IDLE, SHIFT, ROUND, DONE.
//  IDLE:
//   - in_valid&in_ready captures inputs.
//   - mant = top WFRAC+1 bits starting at the leading-one position.
//   - guard = next bit below mant; sticky = OR of all remaining lower bits.
//   - tiny=1: sh = 1-expsum, saturated to WFRAC+3; next state SHIFT.
//   - tiny=0: sh = 0; next state ROUND.
//  SHIFT (1 bit per cycle):
//   - Each cycle: {mant,guard} >>= 1; sticky |= old guard; sh--.
//   - Go to ROUND when sh reaches 0. Working exponent is set to 0.
//  ROUND (round to nearest-even):
//   - inc = guard & (sticky | mant[0]).
//   - mant += inc, computed WFRAC+2 bits wide.
//   - Normal path: carry out of the hidden bit shifts mant right by 1 and increments exp.
//   - Tiny path: carry into the hidden bit gives exp=1 (smallest normal).
//   - inexact = guard | sticky.
//   - Go to DONE.
//  DONE:
//   - out_valid=1; result and flags held stable until out_ready=1; then return to IDLE.
//   - in_ready=0 in every state except IDLE.
//  Overflow:
//   - Final exp >= 2^WEXP-1 (either from expsum or from the rounding carry).
//   - result = {sign, all-ones exp, 0 frac}; overflow=1; inexact=1.
//  Tiny results:
//   - underflow = tiny & inexact (exact subnormals raise no flag).
//   - A fully shifted-out value gives ±0 with inexact=1 if any bit was nonzero.
//  Exact zero input (prod=0) gives ±0 with no flags. Sign is preserved.
//  Latency from in accept to out_valid: 2 cycles (normal), 2+sh cycles (tiny).
//  Throughput: one operation per (latency + 1) cycles when out_ready=1.
//  Asserting rst_n low in any state aborts the operation immediately; no partial result is emitted.
// TESTING
//  1. 1.0*1.0: expsum=127, tiny=0, twoormore=0, prod=48'h400000000000
//     -> result=32'h3F800000 two cycles after accept; no flags.
//  2. RNE tie-up: expsum=127, prod=48'h400000C00000
//     -> result=32'h3F800002, inexact=1.
//     Same with prod=48'h400000400000 -> 32'h3F800000, inexact=1.
//  3. Subnormal: expsum=10'h3FF (-1), tiny=1, prod=48'h400000000000
//     -> sh=2, result=32'h00200000, no flags; out_valid 4 cycles after accept.
//  4. Overflow: expsum=255, tiny=0, sign=1
//     -> result=32'hFF800000, overflow=1, inexact=1.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE
//     -> result stable, in_ready=0; then one transfer on out_ready=1, in_ready=1 the next cycle.
//  6. Reset mid-op: assert rst_n=0 during SHIFT with sh=20 pending
//     -> out_valid=0 and in_ready=1 immediately; no result is ever emitted.

Source files
------------

// File: rtl/mul_round_pack_if.sv
// rtl/mul_round_pack_if.sv - operand/result handshake bundle for the multiplier round-and-pack stage
interface mul_round_pack_if #(
    parameter int WEXP    = 8,
    parameter int WFRAC   = 23,
    parameter int WEXPSUM = 10,
    parameter int WPROD   = 48
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    sign;
    logic [WEXPSUM-1:0]      expsum;
    logic                    tiny;
    logic                    twoormore;
    logic [WPROD-1:0]        prod;
    logic                    out_valid;
    logic                    out_ready;
    logic [WEXP+WFRAC:0]     result;
    logic                    overflow;
    logic                    underflow;
    logic                    inexact;

    modport slave (
        input  in_valid, sign, expsum, tiny, twoormore, prod, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );

    modport master (
        output in_valid, sign, expsum, tiny, twoormore, prod, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/mul_round_pack.sv
// rtl/mul_round_pack.sv - denormalise, round-to-nearest-even and pack a multiplier product
module mul_round_pack #(
    parameter int WEXP    = 8,
    parameter int WFRAC   = 23,
    parameter int WEXPSUM = 10,
    parameter int WPROD   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_round_pack_if.slave  bus
);
    localparam int SHW = $clog2(WFRAC + 4);
    localparam logic [WEXPSUM:0]        SH_MAX  = (WEXPSUM+1)'(WFRAC + 3);
    localparam logic signed [WEXPSUM:0] EXP_MAX = (WEXPSUM+1)'((1 << WEXP) - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t               state_q, state_d;
    logic [WFRAC:0]       mant_q, mant_d;
    logic                 guard_q, guard_d;
    logic                 sticky_q, sticky_d;
    logic [WEXPSUM-1:0]   exp_q, exp_d;
    logic [SHW-1:0]       sh_q, sh_d;
    logic                 sign_q, sign_d;
    logic                 tiny_q, tiny_d;
    logic                 zero_q, zero_d;
    logic [WEXP+WFRAC:0]  result_q, result_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 inexact_q, inexact_d;

    logic                 sticky_hi, sticky_lo;
    logic [WEXPSUM:0]     sh_full;
    logic                 rnd_inc;
    logic [WFRAC+1:0]     rnd_sum;
    logic signed [WEXPSUM:0] rnd_exp;
    logic [WFRAC-1:0]     rnd_frac;
    logic                 rnd_inexact;

    assign sticky_hi = |bus.prod[WPROD-WFRAC-3:0];
    assign sticky_lo = |bus.prod[WPROD-WFRAC-4:0];
    assign sh_full   = (WEXPSUM+1)'(1) - {bus.expsum[WEXPSUM-1], bus.expsum};

    // Rounding datapath; only consumed in ROUND.
    always_comb begin
        rnd_inc     = guard_q & (sticky_q | mant_q[0]);
        rnd_sum     = {1'b0, mant_q} + {{(WFRAC+1){1'b0}}, rnd_inc};
        rnd_inexact = guard_q | sticky_q;
        rnd_exp     = $signed({exp_q[WEXPSUM-1], exp_q});
        rnd_frac    = rnd_sum[WFRAC-1:0];
        if (tiny_q) begin
            // a carry into the hidden bit promotes the subnormal to the smallest normal
            rnd_exp = $signed({{WEXPSUM{1'b0}}, rnd_sum[WFRAC]});
        end else if (rnd_sum[WFRAC+1]) begin
            rnd_exp  = rnd_exp + $signed((WEXPSUM+1)'(1));
            rnd_frac = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        exp_d       = exp_q;
        sh_d        = sh_q;
        sign_d      = sign_q;
        tiny_d      = tiny_q;
        zero_d      = zero_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.sign;
                    tiny_d = bus.tiny;
                    zero_d = (bus.prod == '0);
                    if (bus.twoormore) begin
                        mant_d   = bus.prod[WPROD-1 -: WFRAC+1];
                        guard_d  = bus.prod[WPROD-WFRAC-2];
                        sticky_d = sticky_hi;
                    end else begin
                        mant_d   = bus.prod[WPROD-2 -: WFRAC+1];
                        guard_d  = bus.prod[WPROD-WFRAC-3];
                        sticky_d = sticky_lo;
                    end
                    if (bus.tiny) begin
                        exp_d   = '0;
                        sh_d    = (sh_full > SH_MAX) ? SH_MAX[SHW-1:0] : sh_full[SHW-1:0];
                        state_d = SHIFT;
                    end else begin
                        exp_d   = bus.expsum;
                        sh_d    = '0;
                        state_d = ROUND;
                    end
                end
            end
            SHIFT: begin
                {mant_d, guard_d} = {1'b0, mant_q, guard_q} >> 1;
                sticky_d = sticky_q | guard_q;
                sh_d     = sh_q - 1'b1;
                if (sh_q == SHW'(1)) state_d = ROUND;
            end
            ROUND: begin
                if (zero_q) begin
                    result_d    = {sign_q, {(WEXP+WFRAC){1'b0}}};
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b0;
                end else if (rnd_exp >= EXP_MAX) begin
                    result_d    = {sign_q, {WEXP{1'b1}}, {WFRAC{1'b0}}};
                    overflow_d  = 1'b1;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b1;
                end else begin
                    result_d    = {sign_q, rnd_exp[WEXP-1:0], rnd_frac};
                    overflow_d  = 1'b0;
                    underflow_d = tiny_q & rnd_inexact;
                    inexact_d   = rnd_inexact;
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            exp_q       <= '0;
            sh_q        <= '0;
            sign_q      <= 1'b0;
            tiny_q      <= 1'b0;
            zero_q      <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            exp_q       <= exp_d;
            sh_q        <= sh_d;
            sign_q      <= sign_d;
            tiny_q      <= tiny_d;
            zero_q      <= zero_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_mul_round_pack.sv
// tb/tb_mul_round_pack.sv - scoreboard bench for mul_round_pack
module tb_mul_round_pack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mul_round_pack_if bus ();

    mul_round_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: place the normalised significand in a wide field, shift, then RNE on the remainder.
    function automatic exp_t model(input logic s, input logic signed [9:0] e, input logic tn,
                                   input logic two, input logic [47:0] p);
        exp_t m;
        logic [47:0]  n;
        logic [127:0] v;
        logic [24:0]  r;
        logic         half, rest, inc;
        int           sh, ex;
        logic [22:0]  fr;
        sh = tn ? (1 - int'(e)) : 0;
        if (sh > 26) sh = 26;
        m.lat = 2 + sh;
        m.ovf = 1'b0;
        m.unf = 1'b0;
        m.inx = 1'b0;
        if (p == 48'h0) begin
            m.res = {s, 31'h0};
            return m;
        end
        n = two ? p : (p << 1);
        v = {n, 80'h0} >> sh;
        half = v[103];
        rest = |v[102:0];
        inc  = half & (rest | v[104]);
        r = {1'b0, v[127:104]} + {24'h0, inc};
        if (tn) begin
            ex = r[23] ? 1 : 0;
            fr = r[22:0];
        end else if (r[24]) begin
            ex = int'(e) + 1;
            fr = 23'h0;
        end else begin
            ex = int'(e);
            fr = r[22:0];
        end
        m.inx = half | rest;
        if (!tn && ex >= 255) begin
            m.res = {s, 8'hFF, 23'h0};
            m.ovf = 1'b1;
            m.inx = 1'b1;
        end else begin
            m.res = {s, 8'(ex), fr};
            m.unf = tn & m.inx;
        end
        return m;
    endfunction

    task automatic send(input logic s, input logic signed [9:0] e, input logic two,
                        input logic [47:0] p, input bit push);
        int n;
        @(negedge clk);
        bus.sign      = s;
        bus.expsum    = e;
        bus.tiny      = (e <= 0);
        bus.twoormore = two;
        bus.prod      = p;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) sb.push_back(model(s, e, (e <= 0), two, p));
    endtask

    task automatic recv(input int hold);
        exp_t x;
        int   cnt;
        logic [31:0] held;
        cnt = 0;
        while (!bus.out_valid && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checks++;
        if (!bus.out_valid || sb.size() == 0) begin
            errors++;
            $display("FAIL recv_timeout: out_valid=%b queued=%0d", bus.out_valid, sb.size());
            return;
        end
        x = sb.pop_front();
        checks++;
        if (cnt !== x.lat - 1) begin
            errors++;
            $display("FAIL latency: got %0d edges required %0d", cnt, x.lat - 1);
        end
        checks++;
        if (bus.result !== x.res) begin
            errors++;
            $display("FAIL result: got %h required %h", bus.result, x.res);
        end
        checks++;
        if ({bus.overflow, bus.underflow, bus.inexact} !== {x.ovf, x.unf, x.inx}) begin
            errors++;
            $display("FAIL flags(o,u,i): got %b%b%b required %b%b%b", bus.overflow,
                     bus.underflow, bus.inexact, x.ovf, x.unf, x.inx);
        end
        held = bus.result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.result !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure: result=%h out_valid=%b in_ready=%b required %h 1 0",
                         bus.result, bus.out_valid, bus.in_ready, held);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] req);
        checks++;
        if (bus.result !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, bus.result, req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0 ||
            {bus.overflow, bus.underflow, bus.inexact} !== 3'b000) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%h flags=%b%b%b required 1 0 0 000",
                     bus.in_ready, bus.out_valid, bus.result, bus.overflow, bus.underflow, bus.inexact);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send(1'b0, 10'sd127, 1'b0, 48'h400000000000, 1'b1);
        recv(0);
        check_word("one_times_one", 32'h3F800000);
    endtask

    task automatic test_rounding();
        send(1'b0, 10'sd127, 1'b0, 48'h400000C00000, 1'b1);
        recv(0);
        check_word("rne_tie_up", 32'h3F800002);
        send(1'b0, 10'sd127, 1'b0, 48'h400000400000, 1'b1);
        recv(0);
        check_word("rne_tie_even", 32'h3F800000);
        send(1'b0, 10'sd127, 1'b1, 48'hFFFFFF800000, 1'b1);
        recv(0);
        check_word("round_carry", 32'h40000000);
    endtask

    task automatic test_subnormal();
        send(1'b0, -10'sd1, 1'b0, 48'h400000000000, 1'b1);
        recv(0);
        check_word("subnormal", 32'h00200000);
        send(1'b1, -10'sd60, 1'b0, 48'h400000000001, 1'b1);
        recv(0);
        check_word("flush_zero", 32'h80000000);
    endtask

    task automatic test_overflow();
        send(1'b1, 10'sd255, 1'b0, 48'h400000000000, 1'b1);
        recv(0);
        check_word("overflow", 32'hFF800000);
    endtask

    task automatic test_zero();
        send(1'b1, 10'sd100, 1'b0, 48'h0, 1'b1);
        recv(0);
        check_word("exact_zero", 32'h80000000);
    endtask

    task automatic test_backpressure();
        send(1'b0, 10'sd130, 1'b1, 48'hA5A5A5A5A5A5, 1'b1);
        recv(5);
    endtask

    task automatic test_reset_midop();
        bit seen;
        send(1'b0, -10'sd19, 1'b0, 48'h400000000000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midop: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_result: out_valid seen=%b required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] p;
        logic signed [9:0] e;
        logic two;
        for (int i = 0; i < 40; i++) begin
            e   = 10'($signed($urandom_range(0, 300)) - 40);
            two = 1'($urandom);
            p   = 48'({$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) p[20:0] = '0;
            if (two) p[47] = 1'b1;
            else begin
                p[47] = 1'b0;
                p[46] = 1'b1;
            end
            send(1'($urandom), e, two, p, 1'b1);
            recv(0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.sign      = 1'b0;
        bus.expsum    = '0;
        bus.tiny      = 1'b0;
        bus.twoormore = 1'b0;
        bus.prod      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_subnormal();
        test_overflow();
        test_zero();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
